// File: rtl/chess_pkg.sv
// Shared chess definitions: piece/colour codes and the 16-bit move word layout
// produced by the cell grid and carried through the per-column move FIFOs.
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        PAWN    = 3'd1,
        KNIGHT  = 3'd2,
        BISHOP  = 3'd3,
        ROOK    = 3'd4,
        QUEEN   = 3'd5,
        KING    = 3'd6,
        NOTUSED = 3'd7
    } piece_e;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } color_e;

    localparam int MOVE_W    = 16;
    localparam int COORD_W   = 3;
    localparam int PIECE_W   = 3;
    localparam int FROMX_LSB = 13;
    localparam int FROMY_LSB = 10;
    localparam int TOX_LSB   = 7;
    localparam int TOY_LSB   = 4;
    localparam int PIECE_LSB = 1;
    localparam int CAP_LSB   = 0;

    localparam logic [MOVE_W-1:0] PVOID = '0;

    typedef struct packed {
        logic [COORD_W-1:0] from_x;
        logic [COORD_W-1:0] from_y;
        logic [COORD_W-1:0] to_x;
        logic [COORD_W-1:0] to_y;
        piece_e             piece;
        logic               capture;
    } move_t;

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: picks the first requester at or
// after ptr (wrapping 7->0); grant is one-hot only when en is high.
module rr_arbiter8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic       en,
    output logic [7:0] grant,
    output logic [2:0] gidx
);

    logic [7:0] w_rot;
    logic       w_found;

    // w_rot[k] is the request k positions after the pointer
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign w_rot[gi] = req[3'(ptr + 3'(gi))];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        gidx    = ptr;
        grant   = '0;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                gidx    = ptr + 3'(k);
            end
        end
        if (en && w_found) begin
            grant[gidx] = 1'b1;
        end
    end

endmodule

// File: rtl/column_move_fifo.sv
// Per-column move collector: round-robin grants one cell move per cycle into a
// FIFO and presents the head to the move-list collector with valid/ready.
module column_move_fifo
    import chess_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int NCELL = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    newboard,
    input  logic [NCELL-1:0]        req,
    input  logic [NCELL*MOVE_W-1:0] movein,
    output logic [NCELL-1:0]        ack,
    output logic [MOVE_W-1:0]       outmove,
    output logic                    outvalid,
    input  logic                    outready,
    output logic [AW:0]             count,
    output logic                    full,
    output logic                    empty,
    output logic [7:0]              movecount,
    output logic                    idle
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [MOVE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [2:0]        r_rr;
    logic [7:0]        r_movecount;
    logic [MOVE_W-1:0] r_head;

    logic              w_full;
    logic              w_empty;
    logic              w_en;
    logic [7:0]        w_grant;
    logic [2:0]        w_gidx;
    logic              w_push;
    logic              w_pop;
    logic [MOVE_W-1:0] w_win_move;
    logic [AW-1:0]     w_rd_next;
    logic [AW:0]       w_count_next;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    // Gating on registered full keeps outready out of the grant path
    assign w_en    = resetn && !newboard && !w_full;

    rr_arbiter8 u_arb (
        .req   (req),
        .ptr   (r_rr),
        .en    (w_en),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    assign w_push     = |w_grant;
    assign w_pop      = !w_empty && outready;
    assign w_win_move = movein[32'(w_gidx) * MOVE_W +: MOVE_W];
    assign w_rd_next  = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_win_move;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || newboard) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rr        <= '0;
            r_movecount <= '0;
            r_head      <= PVOID;
        end else begin
            r_count  <= w_count_next;
            r_rd_ptr <= w_rd_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_rr     <= w_gidx + 3'd1;
                if (r_movecount != 8'hFF) begin
                    r_movecount <= r_movecount + 8'd1;
                end
            end
            // New head bypasses the array when it is the entry being written now
            if (w_push || w_pop) begin
                r_head <= (w_push && (w_rd_next == r_wr_ptr)) ? w_win_move
                                                               : r_mem[w_rd_next];
            end
        end
    end

    assign ack       = w_grant;
    assign outmove   = r_head;
    assign outvalid  = !w_empty;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign movecount = r_movecount;
    assign idle      = w_empty && (req == '0);

endmodule

// File: tb/tb_column_move_fifo.sv
// Bench for column_move_fifo: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_column_move_fifo;
    import chess_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         newboard;
    logic [7:0]   req;
    logic [127:0] movein;
    logic [7:0]   ack;
    logic [15:0]  outmove;
    logic         outvalid;
    logic         outready;
    logic [AW:0]  count;
    logic         full;
    logic         empty;
    logic [7:0]   movecount;
    logic         idle;

    logic [15:0]  cell_mv [8];

    always #5 clk = ~clk;

    always_comb begin
        movein = '0;
        for (int i = 0; i < 8; i++) movein[16*i +: 16] = cell_mv[i];
    end

    column_move_fifo #(.DEPTH(DEPTH), .AW(AW), .NCELL(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .newboard  (newboard),
        .req       (req),
        .movein    (movein),
        .ack       (ack),
        .outmove   (outmove),
        .outvalid  (outvalid),
        .outready  (outready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .movecount (movecount),
        .idle      (idle)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        resetn   = 1'b1;
        newboard = 1'b1;
        req      = 8'h00;
        outready = 1'b0;
        next_cycle();
        newboard = 1'b0;
    endtask

    typedef struct {
        logic        rstn;
        logic        nb;
        logic [7:0]  rq;
        logic        rdy;
        logic        chk_state;
        logic [7:0]  e_ack;
        int          e_cnt;
        logic        e_vld;
        logic        chk_mv;
        logic [15:0] e_mv;
        int          e_mc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(logic rstn, logic nb, logic [7:0] rq, logic rdy,
                                    logic cs, logic [7:0] ea, int ec, logic ev,
                                    logic cm, logic [15:0] emv, int emc);
        vec_t v;
        v.rstn = rstn; v.nb = nb; v.rq = rq; v.rdy = rdy; v.chk_state = cs;
        v.e_ack = ea; v.e_cnt = ec; v.e_vld = ev; v.chk_mv = cm; v.e_mv = emv; v.e_mc = emc;
        tbl.push_back(v);
    endfunction

    // reference model state
    logic [15:0] q[$];
    int          rr_m;
    int          mc_m;
    bit          fresh;
    bit          pend [8];

    initial begin
        logic [15:0] cm_init [8];
        cm_init = '{16'h1100, 16'h2201, 16'h3302, 16'hA5C3,
                    16'h5504, 16'h6605, 16'h7706, 16'h8807};
        for (int i = 0; i < 8; i++) cell_mv[i] = cm_init[i];
        resetn = 1'b0; newboard = 1'b0; req = 8'hFF; outready = 1'b0;

        // reset, single move, all-8 round robin and drain
        add_vec(0, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 16'h0, 0);
        add_vec(0, 0, 8'hFF, 0, 1, 8'h00, 0, 0, 1, 16'h0, 0);
        add_vec(1, 0, 8'h08, 0, 1, 8'h08, 0, 0, 1, 16'h0, 0);
        add_vec(1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 1, 16'hA5C3, 1);
        add_vec(1, 1, 8'h00, 0, 1, 8'h00, 1, 1, 1, 16'hA5C3, 1);
        add_vec(1, 0, 8'hFF, 0, 1, 8'h01, 0, 0, 1, 16'h0, 0);
        for (int k = 1; k < 8; k++)
            add_vec(1, 0, 8'(8'hFF << k), 0, 1, 8'(8'h01 << k), k, 1, 1, cm_init[0], k);
        add_vec(1, 0, 8'h00, 1, 1, 8'h00, 8, 1, 1, cm_init[0], 8);
        for (int j = 1; j < 8; j++)
            add_vec(1, 0, 8'h00, 1, 1, 8'h00, 8 - j, 1, 1, cm_init[j], 8);
        add_vec(1, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 16'h0, 8);

        #1;
        for (int v = 0; v < tbl.size(); v++) begin
            resetn = tbl[v].rstn; newboard = tbl[v].nb;
            req = tbl[v].rq; outready = tbl[v].rdy;
            @(negedge clk);
            $display("[TB] vec %0d rstn=%0b nb=%0b req=%02h rdy=%0b ack=%02h count=%0d valid=%0b move=%04h",
                     v, resetn, newboard, req, outready, ack, count, outvalid, outmove);
            chk("tbl_ack", ack, tbl[v].e_ack);
            if (tbl[v].chk_state) begin
                chk("tbl_count", count, tbl[v].e_cnt);
                chk("tbl_valid", outvalid, tbl[v].e_vld);
                chk("tbl_empty", empty, tbl[v].e_cnt == 0);
                chk("tbl_full", full, 0);
                chk("tbl_movecount", movecount, tbl[v].e_mc);
                if (tbl[v].chk_mv) chk("tbl_outmove", outmove, tbl[v].e_mv);
            end
            next_cycle();
        end

        // fill to full from cell 0, then one pop frees exactly one slot
        flush();
        req = 8'h01;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("fill_ack", ack, 8'h01);
            chk("fill_count", count, i);
            next_cycle();
        end
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_count", count, DEPTH);
        chk("full_ack", ack, 8'h00);
        next_cycle();
        outready = 1'b1;
        @(negedge clk);
        chk("full_pop_ack", ack, 8'h00);
        chk("full_pop_valid", outvalid, 1);
        next_cycle();
        outready = 1'b0;
        @(negedge clk);
        chk("after_pop_count", count, DEPTH - 1);
        chk("after_pop_full", full, 0);
        chk("after_pop_ack", ack, 8'h01);
        next_cycle();
        @(negedge clk);
        chk("refull_count", count, DEPTH);
        chk("refull_ack", ack, 8'h00);
        next_cycle();

        // fairness between cells 2 and 5 with a streaming consumer
        flush();
        req = 8'h24; outready = 1'b1;
        begin
            int eg, pg;
            eg = 2; pg = 2;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("fair_ack", ack, 8'(8'h01 << eg));
                if (k == 0) chk("fair_count0", count, 0);
                else begin
                    chk("fair_count", count, 1);
                    chk("fair_outmove", outmove, cell_mv[pg]);
                end
                pg = eg;
                eg = (eg == 2) ? 5 : 2;
                next_cycle();
            end
        end

        // flush with five entries queued and rr advanced past cell 0
        flush();
        begin
            logic [7:0] masks [5];
            masks = '{8'h1F, 8'h1E, 8'h1C, 8'h18, 8'h10};
            for (int k = 0; k < 5; k++) begin
                req = masks[k];
                @(negedge clk);
                chk("pre_flush_ack", ack, 8'(8'h01 << k));
                next_cycle();
            end
        end
        newboard = 1'b1; req = 8'hFF;
        @(negedge clk);
        chk("flush_ack", ack, 8'h00);
        chk("flush_count_before", count, 5);
        next_cycle();
        newboard = 1'b0;
        @(negedge clk);
        chk("flush_count", count, 0);
        chk("flush_valid", outvalid, 0);
        chk("flush_empty", empty, 1);
        chk("flush_movecount", movecount, 0);
        chk("flush_outmove", outmove, 16'h0);
        chk("flush_first_grant", ack, 8'h01);
        next_cycle();

        // movecount saturation
        flush();
        req = 8'h01; outready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            chk("sat_movecount", movecount, (k < 255) ? k : 255);
            next_cycle();
        end

        // randomized run against the queue model
        for (int i = 0; i < 8; i++) pend[i] = 0;
        req = 8'h00;
        q.delete(); rr_m = 0; mc_m = 0; fresh = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int win;
            logic [7:0] e_ack;
            if (cyc == 0) resetn = 1'b0;
            else resetn = ($urandom_range(0, 299) != 0);
            newboard = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 8; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    cell_mv[i] = 16'($urandom);
                end
                req[i] = pend[i];
            end
            if (((cyc / 400) % 2) == 1) outready = ($urandom_range(0, 3) != 0);
            else outready = ($urandom_range(0, 3) == 0);

            @(negedge clk);
            win = -1;
            if (resetn && !newboard && q.size() < DEPTH) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (rr_m + k) % 8;
                    if (win < 0 && req[idx]) win = idx;
                end
            end
            e_ack = (win >= 0) ? 8'(8'h01 << win) : 8'h00;
            chk("rnd_ack", ack, e_ack);
            if (cyc > 0) begin
                chk("rnd_count", count, q.size());
                chk("rnd_valid", outvalid, q.size() > 0);
                chk("rnd_full", full, q.size() == DEPTH);
                chk("rnd_empty", empty, q.size() == 0);
                chk("rnd_idle", idle, (q.size() == 0) && (req == 8'h00));
                chk("rnd_movecount", movecount, mc_m);
                if (q.size() > 0) chk("rnd_outmove", outmove, q[0]);
                else if (fresh) chk("rnd_outmove_clr", outmove, 16'h0);
            end

            @(posedge clk);
            if (!resetn || newboard) begin
                q.delete(); rr_m = 0; mc_m = 0; fresh = 1;
            end else begin
                if (q.size() > 0 && outready) void'(q.pop_front());
                if (win >= 0) begin
                    q.push_back(cell_mv[win]);
                    rr_m = (win + 1) % 8;
                    mc_m = (mc_m < 255) ? mc_m + 1 : 255;
                    fresh = 0;
                    pend[win] = 0;
                end
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/column_move_fifo.md
Name: column_move_fifo

Overview:
- Collects move entries emitted by the 8 cellUnits of one board column.
- Arbitrates them round-robin, one per cycle, into a FIFO.
- Presents them with a valid/ready handshake to the downstream move-list collector.
- One instance per column, placed directly downstream of the cell grid's move-list outputs.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AW, 4, log2(DEPTH); count width is AW+1.
- NCELL, 8, requesting cells per column; ports are sized for 8.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- newboard  in  1  start of new board evaluation; synchronous flush.
- req  in  8  req[i] high means cell at ypos=i presents a move.
- movein  in  128  move of cell i at bits [16i+15:16i].
- ack  out  8  one-hot or zero; ack[i] high means movein of cell i is captured at this edge.
- outmove  out  16  head-of-FIFO move.
- outvalid  out  1  head valid.
- outready  in  1  consumer accepts the head when outvalid is also high.
- count  out  AW+1  occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- movecount  out  8  moves accepted since the last flush; saturates at 255.
- idle  out  1  empty and req==0.

Behaviour:
- Move format: [15:13] from_x, [12:10] from_y, [9:7] to_x, [6:4] to_y, [3:1] piece code (PAWN..QUEEN), [0] capture.
- Reset (resetn=0 at an edge): pointers, count, movecount and rr pointer cleared. Afterwards outvalid=0, empty=1, full=0, outmove=0. ack is forced to 0 while resetn=0.
- newboard=1: identical clear to reset, with priority over push/pop in that cycle. ack=0 during newboard.
- Arbitration is combinational from req, rr pointer and registered full. The winner is the first requesting index at or after rr, wrapping 7->0.
  - push = winner exists AND NOT full AND NOT newboard AND resetn.
  - ack[winner] = push.
  - On push, rr <= winner+1 (mod 8); otherwise rr holds.
- Cells hold req and movein stable until acked. The block never drops an asserted request.
- pop = outvalid AND outready.
- No push when full, even if pop occurs in the same cycle (no ready-to-grant combinational path).
- Push and pop in the same cycle: count unchanged; write and read pointers both advance.
- Count rules: push only gives count+1; pop only gives count-1; pointers wrap modulo DEPTH.
- Latency: an entry acked at edge N is visible on outmove with outvalid=1 after edge N, if the FIFO was empty. No fall-through in the same cycle.
- outmove is driven from the registered head. Its value when outvalid=0 is don't-care, except 0 after reset or flush.
- movecount increments on every push and saturates at 255 (max legal move count is 218).
- outready while empty has no effect. Overflow and underflow are impossible by construction; the bench asserts they never occur.

Decomposition:
- Shared package chess_pkg:
  - piece codes (EMPTY..NOTUSED)
  - WHITE/BLACK
  - move field offsets and widths
  - MOVE_W=16
  - PVOID
- Sub-module rr_arbiter8: inputs req[7:0], ptr[2:0], en; outputs grant one-hot and gidx[2:0]. Purely combinational.
- FIFO storage and pointers live inline in column_move_fifo.

Test Plan:
1. Reset: resetn=0 for 2 cycles with req=8'hFF -> ack=0, outvalid=0, count=0, empty=1, movecount=0.
2. Single move: req=8'h08, movein[63:48]=16'hA5C3, outready=0 -> ack=8'h08 that cycle; next cycle outvalid=1, outmove=16'hA5C3, count=1, movecount=1.
3. All 8 requesting, outready=0, each cell drops req after ack -> acks 0,1,...,7 on consecutive cycles; count=8; outputs then drain in the same order.
4. Fill: continuous requests from cell 0, outready=0 -> full=1 at count=16, ack=0 while full. One pop -> next cycle count=15, then one ack, count=16 again.
5. Fairness: req[2] and req[5] held high, outready=1 -> grant sequence 2,5,2,5...; with simultaneous push/pop, count stays constant.
6. Flush mid-operation: count=5, newboard=1 for one cycle with req=8'hFF -> ack=0 that cycle; next cycle count=0, outvalid=0, movecount=0, first grant goes to cell 0.
